kitchen_timer_ctrl: RTL and testbench
=====================================

// Module: kitchen_timer_ctrl
// PURPOSE
//  Parametrised MM:SS countdown controller for the appliance timer.
//  - Keypad digit entry shifts in from the right (microwave style).
//  - Start/pause/clear FSM with door interlock and a "+30 s" quick-add.
//  - Internal 1 Hz tick prescaler and BCD borrow chain.
//  - Drives four 7-segment digits plus done/alarm status to the panel and buzzer logic.
// PARAMETERS
//  TICK_DIV        50_000_000  clk cycles per 1 s tick (>=2)
//  ALARM_TICKS     3           ticks alarm stays high after reaching 00:00 (>=1)
//  ADD_SECONDS     30          seconds added by start while RUN (1..59)
//  SEG_ACTIVE_LOW  0           1: invert all segment outputs
//  BLANK_LZ        1           1: blank minute digits while they are leading zeros
// PORTS
//  clk        in   1   clock
//  rst        in   1   synchronous reset, active-low
//  key_valid  in   1   one-cycle strobe, key_digit valid
//  key_digit  in   4   BCD key value; values >9 are ignored
//  start      in   1   start/resume; +ADD_SECONDS while running
//  pause      in   1   pause request
//  clear      in   1   pause if running, otherwise clear to 00:00
//  door_open  in   1   level; blocks run
//  seg_mt     out  7   minute tens segments {a,b,c,d,e,f,g}
//  seg_mu     out  7   minute units segments {a,b,c,d,e,f,g}
//  seg_st     out  7   second tens segments {a,b,c,d,e,f,g}
//  seg_su     out  7   second units segments {a,b,c,d,e,f,g}
//  running    out  1   high in RUN
//  done       out  1   high in DONE
//  alarm      out  1   high for first ALARM_TICKS ticks of DONE
// BEHAVIOUR
//  Reset (rst=0 at posedge):
//  - State=IDLE; digits mt,mu,st,su=0; prescaler=0.
//  - running=done=alarm=0.
//  - Segments show 00:00, minutes blanked if BLANK_LZ.
//  FSM states: IDLE, ENTRY, RUN, PAUSE, DONE.
//  Input priority per cycle: clear > door_open > pause > start > key_valid.
//  - Lower-priority inputs are ignored in a cycle where a higher one acts.
//  Entry (IDLE/ENTRY/DONE):
//  - key_valid with digit<=9: {mt,mu,st,su} <= {mu,st,su,key_digit}; state -> ENTRY.
//  - Leaving DONE via a key clears digits first, then shifts in the key.
//  - Digits>9 are ignored; no state change.
//  Start from IDLE/ENTRY/PAUSE, door_open=0, time!=0:
//  - Normalise: if st>5, st-=6 and minutes+=1 (BCD), saturating at 99:59.
//  - Then state -> RUN.
//  - start with time==0 or door_open=1 is ignored.
//  start in RUN:
//  - Add ADD_SECONDS with BCD carry, saturating at 99:59.
//  - Prescaler is not disturbed.
//  RUN:
//  - Prescaler counts 0..TICK_DIV-1; tick fires at TICK_DIV-1.
//  - First tick is TICK_DIV cycles after entry, from a cleared prescaler.
//  - On tick, decrement with BCD borrow: su 0->9 borrows st; st 0->5 borrows mu;
//    mu 0->9 borrows mt.
//  - Tick taking 00:01 -> 00:00: state -> DONE on the same edge.
//  - pause, door_open=1, or clear -> PAUSE. Prescaler is held, digits are held.
//  PAUSE:
//  - start (door closed) -> RUN, prescaler resumes from its held value.
//  - clear -> IDLE with 00:00.
//  DONE:
//  - done=1, digits 00:00.
//  - Prescaler keeps running; alarm=1 for ALARM_TICKS ticks, then 0.
//  - clear or start -> IDLE.
//  IDLE/ENTRY: clear -> IDLE, 00:00. Prescaler is 0 in IDLE, ENTRY and DONE-exit.
//  Outputs: registered from state/digits; seg_* valid the cycle after a digit update.
//  Decoder:
//  - 0..9 use standard patterns (6=1011111, 9=1111011).
//  - Blank=0000000; inverted if SEG_ACTIVE_LOW.
//  - BLANK_LZ blanks mt if 0, and mu if mt=0 and mu=0; st and su are always shown.
//  Reset mid-run: next cycle matches the reset state exactly.
// TESTING (TICK_DIV=4 in bench)
//  1. Keys 1,3,0 then start.
//     - Display 01:30, running=1.
//     - After 4 clks: 01:29. After 31 ticks: 00:59 (borrow chain).
//  2. Keys 9,0 then start.
//     - Normalised to 01:30.
//     - Keys 9,9,9,9 then start: 99:59 (saturate). Start again in RUN: stays 99:59.
//  3. Keys 0,2 then start; run 2 ticks.
//     - DONE on the tick edge, done=1.
//     - alarm=1 for 3 ticks, then 0; start -> IDLE, done=0.
//  4. Running 00:10.
//     - door_open=1 -> PAUSE, digits held.
//     - start with door open ignored; door closed + start resumes without losing
//       prescaler phase.
//  5. Running.
//     - clear -> PAUSE; clear again -> IDLE 00:00.
//     - Simultaneous clear+start in IDLE -> IDLE.
//     - key_digit=4'hA ignored.
//  6. rst=0 mid-RUN at 12:34.
//     - Next cycle: IDLE, all outputs at reset values.
//     - seg_mt/seg_mu blank with BLANK_LZ=1; all segments inverted with SEG_ACTIVE_LOW=1.

Source files
------------

// File: rtl/kitchen_timer_ctrl.sv
// MM:SS appliance countdown timer: keypad entry, start/pause/clear FSM with door
// interlock and quick-add, 1 Hz prescaler, BCD borrow chain, 7-segment panel drive.
module kitchen_timer_ctrl #(
  parameter int unsigned TICK_DIV       = 50_000_000,
  parameter int unsigned ALARM_TICKS    = 3,
  parameter int unsigned ADD_SECONDS    = 30,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          BLANK_LZ       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       door_open,
  output logic [6:0] seg_mt,
  output logic [6:0] seg_mu,
  output logic [6:0] seg_st,
  output logic [6:0] seg_su,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam int unsigned        PSC_W    = $clog2(TICK_DIV);
  localparam logic [PSC_W-1:0]   PSC_MAX  = PSC_W'(TICK_DIV - 1);
  localparam int unsigned        ACNT_W   = $clog2(ALARM_TICKS + 1);
  localparam logic [ACNT_W-1:0]  ACNT_MAX = ACNT_W'(ALARM_TICKS);
  localparam logic [3:0]         ADD_T    = 4'(ADD_SECONDS / 10);
  localparam logic [3:0]         ADD_U    = 4'(ADD_SECONDS % 10);
  localparam logic [6:0]         SEG_INV  = {7{SEG_ACTIVE_LOW}};
  localparam logic [6:0]         SEG_ZERO = 7'b1111110 ^ SEG_INV;
  localparam logic [6:0]         SEG_LZ   = BLANK_LZ ? SEG_INV : SEG_ZERO;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         time_q, time_d;
  logic [PSC_W-1:0]    psc_q, psc_d;
  logic [ACNT_W-1:0]   acnt_q, acnt_d;
  logic [6:0]          seg_mt_q, seg_mu_q, seg_st_q, seg_su_q;
  logic [6:0]          seg_mt_d, seg_mu_d, seg_st_d, seg_su_d;
  logic                running_q, done_q, alarm_q;
  logic                running_d, done_d, alarm_d;
  logic                tick_s, key_ok_s;
  logic [15:0]         time_add_s;

  function automatic logic [7:0] inc_min(input logic [7:0] m);
    if (m[3:0] == 4'd9) inc_min = {m[7:4] + 4'd1, 4'd0};
    else                inc_min = {m[7:4], m[3:0] + 4'd1};
  endfunction

  function automatic logic [15:0] normalise(input logic [15:0] t);
    if (t[7:4] <= 4'd5)          normalise = t;
    else if (t[15:8] == 8'h99)   normalise = 16'h9959;
    else                         normalise = {inc_min(t[15:8]), t[7:4] - 4'd6, t[3:0]};
  endfunction

  function automatic logic [15:0] add_secs(input logic [15:0] t);
    logic       cu;
    logic [3:0] u;
    logic [3:0] tn;
    cu = ({1'b0, t[3:0]} + {1'b0, ADD_U}) > 5'd9;
    u  = t[3:0] + ADD_U + (cu ? 4'd6 : 4'd0);
    tn = t[7:4] + ADD_T + {3'd0, cu};
    if (tn <= 4'd5)              add_secs = {t[15:8], tn, u};
    else if (t[15:8] == 8'h99)   add_secs = 16'h9959;
    else                         add_secs = {inc_min(t[15:8]), tn - 4'd6, u};
  endfunction

  function automatic logic [15:0] dec_time(input logic [15:0] t);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = t;
    if (su != 4'd0) begin
      su = su - 4'd1;
    end else begin
      su = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mu != 4'd0) begin
          mu = mu - 4'd1;
        end else begin
          mu = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    dec_time = {mt, mu, st, su};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  assign tick_s     = (psc_q == PSC_MAX);
  assign key_ok_s   = key_valid && (key_digit <= 4'd9);
  assign time_add_s = start ? add_secs(time_q) : time_q;

  // Next-state: priority clear > door_open > pause > start > key within each state
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    psc_d   = psc_q;
    acnt_d  = acnt_q;
    case (state_q)
      S_IDLE, S_ENTRY: begin
        psc_d = '0;
        if (clear) begin
          state_d = S_IDLE;
          time_d  = 16'h0000;
        end else if (start && !door_open && (time_q != 16'h0000)) begin
          state_d = S_RUN;
          time_d  = normalise(time_q);
        end else if (key_ok_s) begin
          state_d = S_ENTRY;
          time_d  = {time_q[11:0], key_digit};
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (clear || door_open || pause) begin
          state_d = S_PAUSE;
        end else if (tick_s) begin
          psc_d  = '0;
          time_d = dec_time(time_add_s);
          if (time_add_s == 16'h0001) begin
            state_d = S_DONE;
            acnt_d  = '0;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          psc_d  = psc_q + PSC_W'(1);
          time_d = time_add_s;
        end
      end
      S_PAUSE: begin
        if (clear) begin
          state_d = S_IDLE;
          time_d  = 16'h0000;
          psc_d   = '0;
        end else if (start && !door_open && !pause) begin
          state_d = S_RUN;
          time_d  = normalise(time_q);
        end else begin
          state_d = S_PAUSE;
        end
      end
      S_DONE: begin
        // Prescaler free-runs in DONE so the alarm length is counted in whole ticks
        if (tick_s) begin
          psc_d = '0;
          if (acnt_q < ACNT_MAX) acnt_d = acnt_q + ACNT_W'(1);
          else                   acnt_d = acnt_q;
        end else begin
          psc_d = psc_q + PSC_W'(1);
        end
        if (clear || start) begin
          state_d = S_IDLE;
          time_d  = 16'h0000;
          psc_d   = '0;
        end else if (key_ok_s) begin
          state_d = S_ENTRY;
          time_d  = {12'h000, key_digit};
          psc_d   = '0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        time_d  = 16'h0000;
        psc_d   = '0;
        acnt_d  = '0;
      end
    endcase
  end

  // Panel decode from next-state values so outputs track state without extra lag
  always_comb begin
    seg_mt_d  = (BLANK_LZ && (time_d[15:12] == 4'd0)) ? SEG_INV : (seg7(time_d[15:12]) ^ SEG_INV);
    seg_mu_d  = (BLANK_LZ && (time_d[15:8] == 8'h00)) ? SEG_INV : (seg7(time_d[11:8]) ^ SEG_INV);
    seg_st_d  = seg7(time_d[7:4]) ^ SEG_INV;
    seg_su_d  = seg7(time_d[3:0]) ^ SEG_INV;
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
    alarm_d   = (state_d == S_DONE) && (acnt_d < ACNT_MAX);
  end

  // State, time digits, prescaler and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      time_q    <= 16'h0000;
      psc_q     <= '0;
      acnt_q    <= '0;
      seg_mt_q  <= SEG_LZ;
      seg_mu_q  <= SEG_LZ;
      seg_st_q  <= SEG_ZERO;
      seg_su_q  <= SEG_ZERO;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      psc_q     <= psc_d;
      acnt_q    <= acnt_d;
      seg_mt_q  <= seg_mt_d;
      seg_mu_q  <= seg_mu_d;
      seg_st_q  <= seg_st_d;
      seg_su_q  <= seg_su_d;
      running_q <= running_d;
      done_q    <= done_d;
      alarm_q   <= alarm_d;
    end
  end

  assign seg_mt  = seg_mt_q;
  assign seg_mu  = seg_mu_q;
  assign seg_st  = seg_st_q;
  assign seg_su  = seg_su_q;
  assign running = running_q;
  assign done    = done_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_kitchen_timer_ctrl.sv
// Bench for kitchen_timer_ctrl: directed scenarios plus randomized traffic checked
// every cycle against a seconds-based reference model.
module tb_kitchen_timer_ctrl;

  localparam int TD  = 4;
  localparam int AT  = 3;
  localparam int ADD = 30;

  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_RUN   = 2;
  localparam int M_PAUSE = 3;
  localparam int M_DONE  = 4;

  logic       clk = 1'b0;
  logic       rst, key_valid, start, pause, clear, door_open;
  logic [3:0] key_digit;
  logic [6:0] seg_mt_a, seg_mu_a, seg_st_a, seg_su_a;
  logic [6:0] seg_mt_b, seg_mu_b, seg_st_b, seg_su_b;
  logic       running_a, done_a, alarm_a;
  logic       running_b, done_b, alarm_b;

  int    n_checks = 0;
  int    n_errs   = 0;
  string cur_phase = "reset";
  logic  door_lvl = 1'b0;

  // Reference model: entry as a 4-digit decimal number, run time as plain seconds
  int m_mode  = M_IDLE;
  int m_entry = 0;
  int m_total = 0;
  int m_psc   = 0;
  int m_dcyc  = 0;

  always #5 clk = ~clk;

  kitchen_timer_ctrl #(
    .TICK_DIV(TD), .ALARM_TICKS(AT), .ADD_SECONDS(ADD),
    .SEG_ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .pause(pause), .clear(clear), .door_open(door_open),
    .seg_mt(seg_mt_a), .seg_mu(seg_mu_a), .seg_st(seg_st_a), .seg_su(seg_su_a),
    .running(running_a), .done(done_a), .alarm(alarm_a)
  );

  kitchen_timer_ctrl #(
    .TICK_DIV(TD), .ALARM_TICKS(AT), .ADD_SECONDS(ADD),
    .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .pause(pause), .clear(clear), .door_open(door_open),
    .seg_mt(seg_mt_b), .seg_mu(seg_mu_b), .seg_st(seg_st_b), .seg_su(seg_su_b),
    .running(running_b), .done(done_b), .alarm(alarm_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", cur_phase, tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_pat(input int d);
    case (d)
      0:       return 7'b1111110;
      1:       return 7'b0110000;
      2:       return 7'b1101101;
      3:       return 7'b1111001;
      4:       return 7'b0110011;
      5:       return 7'b1011011;
      6:       return 7'b1011111;
      7:       return 7'b1110000;
      8:       return 7'b1111111;
      9:       return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic int to_seconds(input int entry);
    int mins, secs, tot;
    mins = entry / 100;
    secs = entry % 100;
    if (secs > 59) begin
      secs -= 60;
      mins += 1;
    end
    tot = mins * 60 + secs;
    return (tot > 5999) ? 5999 : tot;
  endfunction

  task automatic model_step(input logic r, input logic clr, input logic dr, input logic ps,
                            input logic st, input logic kv, input logic [3:0] kd);
    if (!r) begin
      m_mode = M_IDLE; m_entry = 0; m_total = 0; m_psc = 0; m_dcyc = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_ENTRY: begin
          if (clr) begin
            m_mode = M_IDLE; m_entry = 0;
          end else if (st && !dr && m_entry != 0) begin
            m_total = to_seconds(m_entry); m_mode = M_RUN; m_psc = 0;
          end else if (kv && kd <= 9) begin
            m_entry = (m_entry * 10 + int'(kd)) % 10000; m_mode = M_ENTRY;
          end
        end
        M_RUN: begin
          if (clr || dr || ps) begin
            m_mode = M_PAUSE;
          end else begin
            int t;
            t = m_total;
            if (st) t = (t + ADD > 5999) ? 5999 : t + ADD;
            if (m_psc == TD - 1) begin
              m_psc = 0;
              t = t - 1;
              if (t == 0) begin
                m_mode = M_DONE; m_dcyc = 0;
              end
            end else begin
              m_psc++;
            end
            m_total = t;
          end
        end
        M_PAUSE: begin
          if (clr) begin
            m_mode = M_IDLE; m_entry = 0;
          end else if (!dr && !ps && st) begin
            m_mode = M_RUN;
          end
        end
        default: begin
          if (clr || st) begin
            m_mode = M_IDLE; m_entry = 0;
          end else if (kv && kd <= 9) begin
            m_mode = M_ENTRY; m_entry = int'(kd);
          end else begin
            m_dcyc++;
          end
        end
      endcase
    end
  endtask

  task automatic compare_all();
    int mt, mu, st, su, mm, ss;
    logic [6:0] e_mt, e_mu, e_st, e_su;
    logic [6:0] b_mt, b_mu, b_st, b_su;
    mt = 0; mu = 0; st = 0; su = 0;
    if (m_mode == M_IDLE || m_mode == M_ENTRY) begin
      mt = m_entry / 1000; mu = (m_entry / 100) % 10; st = (m_entry / 10) % 10; su = m_entry % 10;
    end else if (m_mode == M_RUN || m_mode == M_PAUSE) begin
      mm = m_total / 60; ss = m_total % 60;
      mt = mm / 10; mu = mm % 10; st = ss / 10; su = ss % 10;
    end
    e_mt = (mt == 0) ? 7'b0000000 : seg_pat(mt);
    e_mu = (mt == 0 && mu == 0) ? 7'b0000000 : seg_pat(mu);
    e_st = seg_pat(st);
    e_su = seg_pat(su);
    b_mt = ~seg_pat(mt); b_mu = ~seg_pat(mu); b_st = ~seg_pat(st); b_su = ~seg_pat(su);
    check("running", running_a, m_mode == M_RUN);
    check("done",    done_a,    m_mode == M_DONE);
    check("alarm",   alarm_a,   (m_mode == M_DONE) && (m_dcyc < AT * TD));
    check("seg_mt",  seg_mt_a,  e_mt);
    check("seg_mu",  seg_mu_a,  e_mu);
    check("seg_st",  seg_st_a,  e_st);
    check("seg_su",  seg_su_a,  e_su);
    check("inv_mt",  seg_mt_b,  b_mt);
    check("inv_mu",  seg_mu_b,  b_mu);
    check("inv_st",  seg_st_b,  b_st);
    check("inv_su",  seg_su_b,  b_su);
    check("inv_status", {running_b, done_b, alarm_b}, {running_a, done_a, alarm_a});
  endtask

  task automatic cyc(input logic r, input logic clr, input logic dr, input logic ps,
                     input logic st, input logic kv, input logic [3:0] kd);
    rst = r; clear = clr; door_open = dr; pause = ps; start = st;
    key_valid = kv; key_digit = kd;
    @(posedge clk);
    model_step(r, clr, dr, ps, st, kv, kd);
    #1;
    compare_all();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, door_lvl, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic key(input logic [3:0] d);
    cyc(1'b1, 1'b0, door_lvl, 1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic press_start();
    cyc(1'b1, 1'b0, door_lvl, 1'b0, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic press_clear();
    cyc(1'b1, 1'b1, door_lvl, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; door_open = 1'b0; pause = 1'b0; start = 1'b0;
    key_valid = 1'b0; key_digit = 4'd0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    cur_phase = "t1";
    key(4'd1); key(4'd3); key(4'd0); press_start();
    check("t1_run", running_a, 1'b1);
    check("t1_mu", seg_mu_a, seg_pat(1));
    check("t1_st", seg_st_a, seg_pat(3));
    idle_n(4);
    check("t1_129_st", seg_st_a, seg_pat(2));
    check("t1_129_su", seg_su_a, seg_pat(9));
    idle_n(30 * TD);
    check("t1_059_mu", seg_mu_a, 7'b0000000);
    check("t1_059_st", seg_st_a, seg_pat(5));
    check("t1_059_su", seg_su_a, seg_pat(9));
    press_clear(); press_clear();

    cur_phase = "t2";
    key(4'd9); key(4'd0); press_start();
    check("t2_norm_mu", seg_mu_a, seg_pat(1));
    check("t2_norm_st", seg_st_a, seg_pat(3));
    press_clear(); press_clear();
    key(4'd9); key(4'd9); key(4'd9); key(4'd9); press_start();
    check("t2_sat_mt", seg_mt_a, seg_pat(9));
    check("t2_sat_st", seg_st_a, seg_pat(5));
    press_start();
    check("t2_add_mt", seg_mt_a, seg_pat(9));
    check("t2_add_su", seg_su_a, seg_pat(9));
    press_clear(); press_clear();

    cur_phase = "t3";
    key(4'd0); key(4'd2); press_start();
    idle_n(2 * TD - 1);
    check("t3_not_done", done_a, 1'b0);
    idle_n(1);
    check("t3_done", done_a, 1'b1);
    check("t3_alarm_on", alarm_a, 1'b1);
    idle_n(AT * TD - 1);
    check("t3_alarm_last", alarm_a, 1'b1);
    idle_n(1);
    check("t3_alarm_off", alarm_a, 1'b0);
    press_start();
    check("t3_exit_done", done_a, 1'b0);

    cur_phase = "t4";
    key(4'd1); key(4'd0); press_start();
    idle_n(2);
    door_lvl = 1'b1; idle_n(1);
    check("t4_paused", running_a, 1'b0);
    check("t4_held_st", seg_st_a, seg_pat(1));
    press_start();
    check("t4_door_blocks", running_a, 1'b0);
    idle_n(3);
    door_lvl = 1'b0; press_start();
    check("t4_resumed", running_a, 1'b1);
    idle_n(1);
    check("t4_phase_pre", seg_su_a, seg_pat(0));
    idle_n(1);
    check("t4_phase_tick", seg_su_a, seg_pat(9));
    press_clear(); press_clear();

    cur_phase = "t5";
    key(4'd5); press_start(); idle_n(1);
    press_clear();
    check("t5_clr_pause", running_a, 1'b0);
    check("t5_clr_held", seg_su_a, seg_pat(5));
    press_clear();
    check("t5_clr_idle", seg_su_a, seg_pat(0));
    key(4'd7);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    check("t5_clr_start", running_a, 1'b0);
    check("t5_clr_start_su", seg_su_a, seg_pat(0));
    key(4'hA);
    check("t5_key_a", seg_su_a, seg_pat(0));
    key(4'd3);
    check("t5_key_3", seg_su_a, seg_pat(3));
    press_clear();

    cur_phase = "t6";
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); press_start(); idle_n(3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check("t6_run", running_a, 1'b0);
    check("t6_mt", seg_mt_a, 7'b0000000);
    check("t6_su", seg_su_a, seg_pat(0));
    check("t6_inv_mt", seg_mt_b, 7'b0000001);

    cur_phase = "rand";
    for (int ep = 0; ep < 25; ep++) begin
      int nk;
      door_lvl = 1'b0;
      press_clear(); press_clear();
      nk = int'($urandom_range(1, 2));
      for (int k = 0; k < nk; k++) key(4'($urandom_range(0, 12)));
      press_start();
      for (int c = 0; c < 450; c++) begin
        int r;
        r = int'($urandom_range(0, 999));
        if (int'($urandom_range(0, 99)) < (door_lvl ? 10 : 1)) door_lvl = ~door_lvl;
        cyc(r != 0, (r >= 1) && (r < 5), door_lvl, (r >= 5) && (r < 15),
            (r >= 15) && (r < 23), (r >= 23) && (r < 63), 4'($urandom_range(0, 15)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
